// File: rtl/alu_rs_if.sv
// Bus interface for the ALU reservation station: dispatch, CDB broadcast and
// ALU issue signals, grouped so the station and its neighbours share one bundle.
interface alu_rs_if;
  logic        flush_in;
  logic        disp_valid_in;
  logic        disp_ready_out;
  logic [3:0]  disp_func_in;
  logic [2:0]  disp_rob_ix_in;
  logic        disp_src1_rdy_in;
  logic        disp_src2_rdy_in;
  logic [31:0] disp_src1_in;
  logic [31:0] disp_src2_in;
  logic        cdb_valid_in;
  logic [2:0]  cdb_rob_ix_in;
  logic [31:0] cdb_data_in;
  logic        alu_ready_in;
  logic        alu_valid_out;
  logic [31:0] rval1_out;
  logic [31:0] rval2_out;
  logic [3:0]  aluFunc_out;
  logic [2:0]  rob_ix_out;

  modport master (
    output flush_in, disp_valid_in, disp_func_in, disp_rob_ix_in,
           disp_src1_rdy_in, disp_src2_rdy_in, disp_src1_in, disp_src2_in,
           cdb_valid_in, cdb_rob_ix_in, cdb_data_in, alu_ready_in,
    input  disp_ready_out, alu_valid_out, rval1_out, rval2_out,
           aluFunc_out, rob_ix_out
  );

  modport slave (
    input  flush_in, disp_valid_in, disp_func_in, disp_rob_ix_in,
           disp_src1_rdy_in, disp_src2_rdy_in, disp_src1_in, disp_src2_in,
           cdb_valid_in, cdb_rob_ix_in, cdb_data_in, alu_ready_in,
    output disp_ready_out, alu_valid_out, rval1_out, rval2_out,
           aluFunc_out, rob_ix_out
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: DEPTH entries waiting on CDB tags, lowest-index
// dispatch and issue. Define ALU_RS_OCCUPANCY_EN to add the occupancy_out port.
module alu_rs #(
  parameter int DEPTH = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  alu_rs_if.slave bus
`ifdef ALU_RS_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_out
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] src1_rdy;
  logic [DEPTH-1:0] src2_rdy;
  logic [3:0]       func   [DEPTH];
  logic [2:0]       rob_ix [DEPTH];
  logic [31:0]      src1   [DEPTH];
  logic [31:0]      src2   [DEPTH];
  logic             lockout;

  logic [DEPTH-1:0] issuable;
  logic             has_free;
  logic [IW-1:0]    free_ix;
  logic [IW-1:0]    issue_ix;
  logic             do_issue;
  logic             do_disp;
  logic             hit1;
  logic             hit2;
  logic             disp_rdy1;
  logic             disp_rdy2;
  logic [31:0]      disp_val1;
  logic [31:0]      disp_val2;

  // Selection looks only at registered entry state, so a slot freed or woken
  // this cycle becomes visible to dispatch/issue on the following cycle.
  always_comb begin
    issuable = valid & src1_rdy & src2_rdy;
    has_free = ~&valid;
    free_ix  = '0;
    issue_ix = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i])
        free_ix = i[IW-1:0];
      if (issuable[i])
        issue_ix = i[IW-1:0];
    end
    do_issue = bus.alu_ready_in & (|issuable) & ~lockout & ~bus.flush_in;
    do_disp  = bus.disp_valid_in & has_free & ~bus.flush_in;

    hit1 = bus.cdb_valid_in & ~bus.disp_src1_rdy_in &
           (bus.disp_src1_in[2:0] == bus.cdb_rob_ix_in);
    hit2 = bus.cdb_valid_in & ~bus.disp_src2_rdy_in &
           (bus.disp_src2_in[2:0] == bus.cdb_rob_ix_in);
    disp_rdy1 = bus.disp_src1_rdy_in | hit1;
    disp_rdy2 = bus.disp_src2_rdy_in | hit2;
    disp_val1 = hit1 ? bus.cdb_data_in : bus.disp_src1_in;
    disp_val2 = hit2 ? bus.cdb_data_in : bus.disp_src2_in;
  end

  assign bus.disp_ready_out = has_free;

  // Lockout after every issue absorbs the ALU dropping ready one cycle late.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid             <= '0;
      lockout           <= 1'b0;
      bus.alu_valid_out <= 1'b0;
      bus.rval1_out     <= '0;
      bus.rval2_out     <= '0;
      bus.aluFunc_out   <= '0;
      bus.rob_ix_out    <= '0;
    end else if (bus.flush_in) begin
      valid             <= '0;
      lockout           <= 1'b0;
      bus.alu_valid_out <= 1'b0;
    end else begin
      lockout           <= do_issue;
      bus.alu_valid_out <= do_issue;

      for (int i = 0; i < DEPTH; i++) begin
        if (bus.cdb_valid_in && valid[i]) begin
          if (!src1_rdy[i] && src1[i][2:0] == bus.cdb_rob_ix_in) begin
            src1_rdy[i] <= 1'b1;
            src1[i]     <= bus.cdb_data_in;
          end
          if (!src2_rdy[i] && src2[i][2:0] == bus.cdb_rob_ix_in) begin
            src2_rdy[i] <= 1'b1;
            src2[i]     <= bus.cdb_data_in;
          end
        end
      end

      if (do_issue) begin
        valid[issue_ix] <= 1'b0;
        bus.rval1_out   <= src1[issue_ix];
        bus.rval2_out   <= src2[issue_ix];
        bus.aluFunc_out <= func[issue_ix];
        bus.rob_ix_out  <= rob_ix[issue_ix];
      end

      // The free slot is never a valid entry, so it cannot collide with issue.
      if (do_disp) begin
        valid[free_ix]    <= 1'b1;
        func[free_ix]     <= bus.disp_func_in;
        rob_ix[free_ix]   <= bus.disp_rob_ix_in;
        src1_rdy[free_ix] <= disp_rdy1;
        src2_rdy[free_ix] <= disp_rdy2;
        src1[free_ix]     <= disp_val1;
        src2[free_ix]     <= disp_val2;
      end
    end
  end

`ifdef ALU_RS_OCCUPANCY_EN
  localparam int CW = $clog2(DEPTH + 1);

  always_ff @(posedge clk_in) begin
    if (!rst_in || bus.flush_in)
      occupancy_out <= '0;
    else
      occupancy_out <= occupancy_out + CW'(do_disp) - CW'(do_issue);
  end
`endif

endmodule

// File: tb/tb_alu_rs.sv
// Directed scoreboard bench for alu_rs: expected issues are queued at dispatch
// and compared when alu_valid_out pulses. Honours ALU_RS_OCCUPANCY_EN.
module tb_alu_rs;

  localparam logic [3:0] FN_ADD = 4'h0;
  localparam logic [3:0] FN_SUB = 4'h1;
  localparam logic [3:0] FN_AND = 4'h2;
  localparam logic [3:0] FN_OR  = 4'h3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   failed = 0;
  int   pulse_count = 0;
  logic prev_valid = 1'b0;
  logic [70:0] sb_q [$];

  alu_rs_if bus();

`ifdef ALU_RS_OCCUPANCY_EN
  logic [2:0] occupancy;
  alu_rs #(.DEPTH(4)) dut (.clk_in(clk), .rst_in(rst), .bus(bus), .occupancy_out(occupancy));
`else
  alu_rs #(.DEPTH(4)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  function automatic logic [70:0] pack(input logic [2:0] rob, input logic [3:0] fn,
                                       input logic [31:0] r1, input logic [31:0] r2);
    return {rob, fn, r1, r2};
  endfunction

  task automatic check_output(input string tag, input logic [70:0] obs, input logic [70:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] fn, input logic [2:0] rob,
                                input logic r1_rdy, input logic [31:0] r1,
                                input logic r2_rdy, input logic [31:0] r2);
    bus.disp_valid_in    = 1'b1;
    bus.disp_func_in     = fn;
    bus.disp_rob_ix_in   = rob;
    bus.disp_src1_rdy_in = r1_rdy;
    bus.disp_src1_in     = r1;
    bus.disp_src2_rdy_in = r2_rdy;
    bus.disp_src2_in     = r2;
  endtask

  task automatic broadcast(input logic [2:0] tag, input logic [31:0] data);
    bus.cdb_valid_in  = 1'b1;
    bus.cdb_rob_ix_in = tag;
    bus.cdb_data_in   = data;
  endtask

  // One clock: sample just after the edge, score any issue pulse, then drop
  // the single-cycle request inputs.
  task automatic tick();
    logic [70:0] exp;
    @(posedge clk);
    #1;
    check_output("no_back_to_back", {70'd0, (prev_valid === 1'b1 && bus.alu_valid_out === 1'b1)}, 71'd0);
    if (bus.alu_valid_out === 1'b1) begin
      pulse_count++;
      if (sb_q.size() == 0) begin
        check_output("unexpected_issue", {70'd0, bus.alu_valid_out}, 71'd0);
      end else begin
        exp = sb_q.pop_front();
        check_output("issue_payload",
                     {bus.rob_ix_out, bus.aluFunc_out, bus.rval1_out, bus.rval2_out}, exp);
      end
    end
    prev_valid = (bus.alu_valid_out === 1'b1);
    bus.disp_valid_in = 1'b0;
    bus.cdb_valid_in  = 1'b0;
    bus.flush_in      = 1'b0;
  endtask

  task automatic wait_issue(input string tag, input int max_cycles);
    int start;
    start = pulse_count;
    for (int i = 0; i < max_cycles && pulse_count == start; i++)
      tick();
    check_output(tag, 71'(pulse_count - start), 71'd1);
  endtask

  initial begin
    bus.flush_in = 1'b0;
    bus.disp_valid_in = 1'b0;
    bus.disp_func_in = '0;
    bus.disp_rob_ix_in = '0;
    bus.disp_src1_rdy_in = 1'b0;
    bus.disp_src2_rdy_in = 1'b0;
    bus.disp_src1_in = '0;
    bus.disp_src2_in = '0;
    bus.cdb_valid_in = 1'b0;
    bus.cdb_rob_ix_in = '0;
    bus.cdb_data_in = '0;
    bus.alu_ready_in = 1'b0;

    // Reset state
    tick();
    tick();
    check_output("rst_valid", {70'd0, bus.alu_valid_out}, 71'd0);
    check_output("rst_outputs", {bus.rob_ix_out, bus.aluFunc_out, bus.rval1_out, bus.rval2_out}, 71'd0);
    rst = 1'b1;
    tick();
    check_output("rst_disp_ready", {70'd0, bus.disp_ready_out}, 71'd1);
`ifdef ALU_RS_OCCUPANCY_EN
    check_output("rst_occupancy", 71'(occupancy), 71'd0);
`endif

    // Fully ready dispatch issues on the next edge
    bus.alu_ready_in = 1'b1;
    apply_stimulus(FN_ADD, 3'd2, 1'b1, 32'd5, 1'b1, 32'd7);
    sb_q.push_back(pack(3'd2, FN_ADD, 32'd5, 32'd7));
    tick();
    check_output("add_not_yet", {70'd0, bus.alu_valid_out}, 71'd0);
    tick();
    check_output("add_latency", 71'(pulse_count), 71'd1);
    tick();
    check_output("add_pulse_width", {70'd0, bus.alu_valid_out}, 71'd0);
    check_output("add_hold", {39'd0, bus.rval1_out}, 71'd5);

    // Tag wakeup from the CDB; an unrelated tag must not wake the entry
    apply_stimulus(FN_SUB, 3'd5, 1'b1, 32'h20, 1'b0, 32'd3);
    sb_q.push_back(pack(3'd5, FN_SUB, 32'h20, 32'h10));
    tick();
    broadcast(3'd6, 32'hDEAD);
    tick();
    broadcast(3'd3, 32'h10);
    tick();
    check_output("sub_wait", {70'd0, bus.alu_valid_out}, 71'd0);
    tick();
    check_output("sub_wakeup", 71'(pulse_count), 71'd2);

    // Fill all four entries with waiting operands; fifth dispatch is dropped
    apply_stimulus(FN_OR,  3'd0, 1'b0, 32'd1, 1'b1, 32'h100);
    tick();
    apply_stimulus(FN_OR,  3'd1, 1'b0, 32'd6, 1'b1, 32'h101);
    tick();
    apply_stimulus(FN_AND, 3'd2, 1'b0, 32'd4, 1'b1, 32'h102);
    tick();
    apply_stimulus(FN_OR,  3'd3, 1'b0, 32'd7, 1'b1, 32'h103);
    tick();
    check_output("full_not_ready", {70'd0, bus.disp_ready_out}, 71'd0);
`ifdef ALU_RS_OCCUPANCY_EN
    check_output("full_occupancy", 71'(occupancy), 71'd4);
`endif
    apply_stimulus(FN_OR, 3'd0, 1'b1, 32'h55, 1'b1, 32'h66);
    tick();
    broadcast(3'd4, 32'h44);
    sb_q.push_back(pack(3'd2, FN_AND, 32'h44, 32'h102));
    tick();
    check_output("woken_still_full", {70'd0, bus.disp_ready_out}, 71'd0);
    tick();
    check_output("entry2_issue", 71'(pulse_count), 71'd3);
    check_output("slot_freed", {70'd0, bus.disp_ready_out}, 71'd1);

    // Flush beats a simultaneous broadcast that would wake entry 0
    bus.flush_in = 1'b1;
    broadcast(3'd1, 32'hBEEF);
    tick();
    check_output("flush_no_pulse", {70'd0, bus.alu_valid_out}, 71'd0);
    check_output("flush_disp_ready", {70'd0, bus.disp_ready_out}, 71'd1);
`ifdef ALU_RS_OCCUPANCY_EN
    check_output("flush_occupancy", 71'(occupancy), 71'd0);
`endif
    broadcast(3'd6, 32'h66);
    tick();
    broadcast(3'd7, 32'h77);
    tick();
    tick();
    check_output("flush_cleared", 71'(pulse_count), 71'd3);

    // Dispatch bypass from a same-cycle broadcast
    apply_stimulus(FN_AND, 3'd1, 1'b0, 32'd4, 1'b1, 32'd9);
    broadcast(3'd4, 32'hABCD);
    sb_q.push_back(pack(3'd1, FN_AND, 32'hABCD, 32'd9));
    tick();
    tick();
    check_output("bypass_issue", 71'(pulse_count), 71'd4);
    tick();

    // ALU busy: outputs frozen; then entries issue in order, never back to back
    bus.alu_ready_in = 1'b0;
    apply_stimulus(FN_ADD, 3'd3, 1'b1, 32'h11, 1'b1, 32'h12);
    tick();
    apply_stimulus(FN_SUB, 3'd6, 1'b1, 32'h21, 1'b1, 32'h22);
    tick();
    tick();
    check_output("frozen_no_pulse", 71'(pulse_count), 71'd4);
    check_output("frozen_outputs", {bus.rob_ix_out, bus.aluFunc_out, bus.rval1_out, bus.rval2_out},
                 pack(3'd1, FN_AND, 32'hABCD, 32'd9));
    bus.alu_ready_in = 1'b1;
    sb_q.push_back(pack(3'd3, FN_ADD, 32'h11, 32'h12));
    sb_q.push_back(pack(3'd6, FN_SUB, 32'h21, 32'h22));
    tick();
    check_output("first_of_two", 71'(pulse_count), 71'd5);
    tick();
    check_output("lockout_gap", {70'd0, bus.alu_valid_out}, 71'd0);
    wait_issue("second_of_two", 4);

    // Reset mid-operation discards a waiting entry like a flush
    apply_stimulus(FN_OR, 3'd4, 1'b0, 32'd2, 1'b1, 32'h33);
    tick();
    rst = 1'b0;
    tick();
    check_output("midrst_outputs", {bus.rob_ix_out, bus.aluFunc_out, bus.rval1_out, bus.rval2_out}, 71'd0);
    rst = 1'b1;
    tick();
    check_output("midrst_disp_ready", {70'd0, bus.disp_ready_out}, 71'd1);
    broadcast(3'd2, 32'h99);
    tick();
    tick();
    tick();
    check_output("midrst_no_issue", 71'(pulse_count), 71'd6);
    check_output("scoreboard_drained", 71'(sb_q.size()), 71'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
